// File: rtl/credit_accumulator.sv
// Multi-channel coin credit accumulator with purchase deduction and chunked refund.
// Optional lifetime audit counter on total_collected: define CREDIT_AUDIT_TOTAL_EN.
module credit_accumulator #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned MAX_CREDIT  = 200,
    parameter int unsigned CHANGE_UNIT = 25
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       coin_valid,
    input  logic [NUM_CH*WIDTH-1:0] coin_value,
    output logic [NUM_CH-1:0]       coin_reject,
    input  logic                    purchase_req,
    input  logic [WIDTH-1:0]        price,
    output logic                    purchase_ack,
    output logic                    purchase_nack,
    input  logic                    refund_req,
    output logic                    change_valid,
    output logic [WIDTH-1:0]        change_amount,
    input  logic                    change_ready,
    output logic                    refund_done,
    output logic [WIDTH-1:0]        credit,
    output logic [2*WIDTH-1:0]      total_collected
);

    localparam int unsigned SUM_W = WIDTH + $clog2(NUM_CH) + 1;
    localparam int unsigned TOT_W = 2 * WIDTH;
    localparam int unsigned TOT_X = TOT_W + 1;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_REFUND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_credit;
    logic [WIDTH-1:0]    w_credit_nxt;
    logic [NUM_CH-1:0]   r_coin_reject;
    logic [NUM_CH-1:0]   w_coin_reject_nxt;
    logic                r_ack;
    logic                w_ack_nxt;
    logic                r_nack;
    logic                w_nack_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic [NUM_CH-1:0]   w_acc_mask;
    logic [SUM_W-1:0]    w_acc_sum;
    logic [SUM_W-1:0]    w_run;
    logic [SUM_W-1:0]    w_coin;
    logic [SUM_W-1:0]    w_new_credit;
    logic [WIDTH-1:0]    w_change_amt;

    // In-order coin acceptance against a running sum seeded with the held credit
    always_comb begin
        w_acc_mask = '0;
        w_acc_sum  = '0;
        w_run      = SUM_W'(r_credit);
        w_coin     = '0;
        if (r_state == S_IDLE) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                w_coin = SUM_W'(coin_value[i*WIDTH +: WIDTH]);
                if (coin_valid[i] && ((w_run + w_coin) <= SUM_W'(MAX_CREDIT))) begin
                    w_acc_mask[i] = 1'b1;
                    w_run         = w_run + w_coin;
                    w_acc_sum     = w_acc_sum + w_coin;
                end
            end
        end
    end

    assign w_new_credit = SUM_W'(r_credit) + w_acc_sum;
    assign w_change_amt = (r_credit > WIDTH'(CHANGE_UNIT)) ? WIDTH'(CHANGE_UNIT) : r_credit;

    // Next-state and registered-output decode
    always_comb begin
        w_state_nxt       = r_state;
        w_credit_nxt      = r_credit;
        w_coin_reject_nxt = '0;
        w_ack_nxt         = 1'b0;
        w_nack_nxt        = 1'b0;
        w_done_nxt        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_coin_reject_nxt = coin_valid & ~w_acc_mask;
                w_credit_nxt      = WIDTH'(w_new_credit);
                if (refund_req) begin
                    // A purchase losing to a refund is refused rather than left hanging
                    w_nack_nxt = purchase_req;
                    if (w_new_credit == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_REFUND;
                    end
                end else if (purchase_req) begin
                    if (r_credit >= price) begin
                        w_ack_nxt    = 1'b1;
                        w_credit_nxt = WIDTH'(w_new_credit - SUM_W'(price));
                    end else begin
                        w_nack_nxt = 1'b1;
                    end
                end
            end
            S_REFUND: begin
                w_coin_reject_nxt = coin_valid;
                w_nack_nxt        = purchase_req;
                if (change_ready) begin
                    w_credit_nxt = r_credit - w_change_amt;
                    if (r_credit == w_change_amt) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_credit      <= '0;
            r_coin_reject <= '0;
            r_ack         <= 1'b0;
            r_nack        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_coin_reject <= w_coin_reject_nxt;
            r_ack         <= w_ack_nxt;
            r_nack        <= w_nack_nxt;
            r_done        <= w_done_nxt;
        end
    end

`ifdef CREDIT_AUDIT_TOTAL_EN
    logic [TOT_W-1:0] r_total;
    logic [TOT_X-1:0] w_total_sum;

    // Saturating lifetime sum of accepted coins
    assign w_total_sum = {1'b0, r_total} + TOT_X'(w_acc_sum);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_total <= '0;
        end else if (w_total_sum[TOT_W]) begin
            r_total <= '1;
        end else begin
            r_total <= w_total_sum[TOT_W-1:0];
        end
    end

    assign total_collected = r_total;
`else
    assign total_collected = '0;
`endif

    assign change_valid  = (r_state == S_REFUND);
    assign change_amount = (r_state == S_REFUND) ? w_change_amt : '0;
    assign coin_reject   = r_coin_reject;
    assign purchase_ack  = r_ack;
    assign purchase_nack = r_nack;
    assign refund_done   = r_done;
    assign credit        = r_credit;

endmodule

// File: tb/tb_credit_accumulator.sv
// Directed-vector bench for credit_accumulator at WIDTH=8, NUM_CH=4, MAX_CREDIT=200, CHANGE_UNIT=25.
module tb_credit_accumulator;

    logic        clk;
    logic        reset;
    logic [3:0]  coin_valid;
    logic [31:0] coin_value;
    logic [3:0]  coin_reject;
    logic        purchase_req;
    logic [7:0]  price;
    logic        purchase_ack;
    logic        purchase_nack;
    logic        refund_req;
    logic        change_valid;
    logic [7:0]  change_amount;
    logic        change_ready;
    logic        refund_done;
    logic [7:0]  credit;
    logic [15:0] total_collected;

    int n_vec;
    int n_err;

    credit_accumulator #(
        .WIDTH(8), .NUM_CH(4), .MAX_CREDIT(200), .CHANGE_UNIT(25)
    ) dut (
        .clk(clk),
        .reset(reset),
        .coin_valid(coin_valid),
        .coin_value(coin_value),
        .coin_reject(coin_reject),
        .purchase_req(purchase_req),
        .price(price),
        .purchase_ack(purchase_ack),
        .purchase_nack(purchase_nack),
        .refund_req(refund_req),
        .change_valid(change_valid),
        .change_amount(change_amount),
        .change_ready(change_ready),
        .refund_done(refund_done),
        .credit(credit),
        .total_collected(total_collected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        coin_valid   = '0;
        coin_value   = '0;
        purchase_req = 1'b0;
        price        = '0;
        refund_req   = 1'b0;
    endtask

    task automatic set_coin(input int ch, input int val);
        coin_valid[ch]         = 1'b1;
        coin_value[ch*8 +: 8]  = 8'(val);
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        reset        = 1'b0;
        change_ready = 1'b0;
        clear_in();
        tick();
        tick();
        check_eq("rst_credit", 32'(credit), 0);
        check_eq("rst_cvalid", 32'(change_valid), 0);
        check_eq("rst_reject", 32'(coin_reject), 0);
        check_eq("rst_total", 32'(total_collected), 0);
        reset = 1'b1;
        tick();

        // 25 + 0 + 100 from empty credit; zero coin accepted silently
        set_coin(0, 25); set_coin(1, 0); set_coin(2, 100);
        tick(); clear_in();
        check_eq("s1_credit", 32'(credit), 125);
        check_eq("s1_reject", 32'(coin_reject), 0);

        set_coin(0, 25);
        tick(); clear_in();
        check_eq("s2_pre_credit", 32'(credit), 150);

        set_coin(0, 25); set_coin(1, 50);
        tick(); clear_in();
        check_eq("s2_reject", 32'(coin_reject), 4'b0010);
        check_eq("s2_credit", 32'(credit), 175);

        purchase_req = 1'b1; price = 8'd180;
        tick(); clear_in();
        check_eq("s3_nack", 32'(purchase_nack), 1);
        check_eq("s3_nack_ack", 32'(purchase_ack), 0);
        check_eq("s3_nack_credit", 32'(credit), 175);

        purchase_req = 1'b1; price = 8'd120;
        tick(); clear_in();
        check_eq("s3_ack", 32'(purchase_ack), 1);
        check_eq("s3_ack_credit", 32'(credit), 55);
        tick();
        check_eq("s3_ack_pulse", 32'(purchase_ack), 0);

        purchase_req = 1'b1; price = 8'd0;
        tick(); clear_in();
        check_eq("price0_ack", 32'(purchase_ack), 1);
        check_eq("price0_credit", 32'(credit), 55);

        // Refund 55 with dispenser always ready: 25, 25, 5
        change_ready = 1'b1;
        refund_req   = 1'b1;
        tick(); clear_in();
        check_eq("s4_cv0", 32'(change_valid), 1);
        check_eq("s4_amt0", 32'(change_amount), 25);
        tick();
        check_eq("s4_amt1", 32'(change_amount), 25);
        check_eq("s4_credit1", 32'(credit), 30);
        tick();
        check_eq("s4_amt2", 32'(change_amount), 5);
        check_eq("s4_credit2", 32'(credit), 5);
        tick();
        check_eq("s4_cv_end", 32'(change_valid), 0);
        check_eq("s4_done", 32'(refund_done), 1);
        check_eq("s4_credit_end", 32'(credit), 0);
        tick();
        check_eq("s4_done_pulse", 32'(refund_done), 0);

        // Refund with nothing held completes immediately
        refund_req = 1'b1;
        tick(); clear_in();
        check_eq("r0_done", 32'(refund_done), 1);
        check_eq("r0_cv", 32'(change_valid), 0);

        // Fill exactly to MAX_CREDIT, then overflow by one
        set_coin(0, 100); set_coin(1, 100);
        tick(); clear_in();
        check_eq("max_credit", 32'(credit), 200);
        check_eq("max_reject", 32'(coin_reject), 0);
        set_coin(3, 1);
        tick(); clear_in();
        check_eq("over_reject", 32'(coin_reject), 4'b1000);
        check_eq("over_credit", 32'(credit), 200);

        purchase_req = 1'b1; price = 8'd100;
        tick(); clear_in();
        check_eq("s5_pre_credit", 32'(credit), 100);

        // Stalled refund: chunk held, coin and purchase refused
        change_ready = 1'b0;
        refund_req   = 1'b1;
        tick(); clear_in();
        check_eq("s5_cv", 32'(change_valid), 1);
        set_coin(3, 10);
        purchase_req = 1'b1; price = 8'd5;
        tick(); clear_in();
        check_eq("s5_reject", 32'(coin_reject), 4'b1000);
        check_eq("s5_nack", 32'(purchase_nack), 1);
        check_eq("s5_credit", 32'(credit), 100);
        check_eq("s5_amt", 32'(change_amount), 25);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("s5_hold_amt", 32'(change_amount), 25);
            check_eq("s5_hold_credit", 32'(credit), 100);
        end
        change_ready = 1'b1;
        tick();
        check_eq("s5_drain1", 32'(credit), 75);
        tick();
        tick();
        check_eq("s5_drain3", 32'(credit), 25);
        tick();
        check_eq("s5_done", 32'(refund_done), 1);
        check_eq("s5_credit_end", 32'(credit), 0);
        check_eq("s5_cv_end", 32'(change_valid), 0);

        // Asynchronous reset in the middle of a refund
        set_coin(0, 30);
        tick(); clear_in();
        check_eq("s6_credit", 32'(credit), 30);
        change_ready = 1'b0;
        refund_req   = 1'b1;
        tick(); clear_in();
        check_eq("s6_cv", 32'(change_valid), 1);
`ifdef CREDIT_AUDIT_TOTAL_EN
        check_eq("s6_total", 32'(total_collected), 405);
`else
        check_eq("s6_total_off", 32'(total_collected), 0);
`endif
        #3;
        reset = 1'b0;
        #1;
        check_eq("s6_rst_cv", 32'(change_valid), 0);
        check_eq("s6_rst_credit", 32'(credit), 0);
        check_eq("s6_rst_total", 32'(total_collected), 0);
        tick();
        reset = 1'b1;
        tick();
        check_eq("s6_post_cv", 32'(change_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
